leaf_frame_accumulator: RTL and testbench

- Downstream consumer of the 8-bit result stream produced by the parameterized leaf adder.
- Accepts samples over a valid/ready handshake and sums COUNT of them into a frame.
- Adds a per-frame offset, optionally right-shifts the total (averaging), and saturates or wraps it to 16 bits.
- Presents each frame result on a second valid/ready handshake; an early flush closes a partial frame.

---
 rtl/leaf_frame_accumulator.sv | 108 ++++++++++
 tb/tb_leaf_frame_accumulator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_frame_accumulator.sv
// Frame accumulator for the leaf adder's 8-bit result stream.
// It sums COUNT samples, adds OFFSET, applies the averaging shift, then saturates or wraps the total.
module leaf_frame_accumulator #(
  parameter int       COUNT  = 4,
  parameter int       OFFSET = 0,
  parameter bit [3:0] SHIFT  = 4'd0,
  parameter logic     SAT    = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic [8:0]  out_count,
  output logic        out_ovf,
  output logic        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Ready never depends combinationally on the opposite side's valid/ready.
  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_e;

  localparam logic [8:0]  COUNT_W  = 9'(COUNT);
  localparam logic [31:0] OFFSET_W = 32'(OFFSET);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] sum_q, sum_d;
  logic [8:0]  ocnt_q, ocnt_d;
  logic        ovf_q, ovf_d;

  logic        accept;
  logic [31:0] acc_final;
  logic [8:0]  cnt_final;
  logic        close;
  logic [31:0] total;
  logic [31:0] shifted;
  logic        ovf_now;

  assign accept    = (state_q == ST_ACCUM) && in_valid;
  assign acc_final = acc_q + (accept ? {24'd0, in_data} : 32'd0);
  assign cnt_final = cnt_q + {8'd0, accept};
  // A flush also covers a sample accepted in the same cycle.
  assign close     = (state_q == ST_ACCUM) &&
                     ((accept && (cnt_final == COUNT_W)) || (flush && (cnt_final != 9'd0)));
  assign total     = acc_final + OFFSET_W;
  assign shifted   = total >> SHIFT;
  assign ovf_now   = |shifted[31:16];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (close) begin
          state_d = ST_HOLD;
          acc_d   = 32'd0;
          cnt_d   = 9'd0;
          sum_d   = (SAT && ovf_now) ? 16'hFFFF : shifted[15:0];
          ocnt_d  = cnt_final;
          ovf_d   = ovf_now;
        end else begin
          acc_d = acc_final;
          cnt_d = cnt_final;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= 32'd0;
      cnt_q   <= 9'd0;
      sum_q   <= 16'd0;
      ocnt_q  <= 9'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_HOLD);
  assign out_sum     = sum_q;
  assign out_count   = ocnt_q;
  assign out_ovf     = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_leaf_frame_accumulator.sv
// Bench for leaf_frame_accumulator: five differently configured instances share one stimulus stream,
// each checked every cycle against a frame-level model, plus literal expectations from the test plan.
module tb_leaf_frame_accumulator;

  localparam int NI = 5;

  logic        clk;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy  [NI];
  logic        ovld [NI];
  logic [15:0] osum [NI];
  logic [8:0]  ocnt [NI];
  logic        oovf [NI];
  logic        dbg  [NI];

  int cfg_count [NI] = '{4, 4, 256, 256, 1};
  int cfg_off   [NI] = '{0, 3, 1000, 1000, 65535};
  int cfg_shift [NI] = '{0, 2, 0, 0, 0};
  int cfg_sat   [NI] = '{0, 0, 1, 0, 1};

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  leaf_frame_accumulator #(.COUNT(4), .OFFSET(0), .SHIFT(4'd0), .SAT(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .flush(flush), .out_valid(ovld[0]), .out_ready(out_ready), .out_sum(osum[0]),
    .out_count(ocnt[0]), .out_ovf(oovf[0]), .dbg_state_o(dbg[0]));
  leaf_frame_accumulator #(.COUNT(4), .OFFSET(3), .SHIFT(4'd2), .SAT(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .flush(flush), .out_valid(ovld[1]), .out_ready(out_ready), .out_sum(osum[1]),
    .out_count(ocnt[1]), .out_ovf(oovf[1]), .dbg_state_o(dbg[1]));
  leaf_frame_accumulator #(.COUNT(256), .OFFSET(1000), .SHIFT(4'd0), .SAT(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .flush(flush), .out_valid(ovld[2]), .out_ready(out_ready), .out_sum(osum[2]),
    .out_count(ocnt[2]), .out_ovf(oovf[2]), .dbg_state_o(dbg[2]));
  leaf_frame_accumulator #(.COUNT(256), .OFFSET(1000), .SHIFT(4'd0), .SAT(1'b0)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
    .flush(flush), .out_valid(ovld[3]), .out_ready(out_ready), .out_sum(osum[3]),
    .out_count(ocnt[3]), .out_ovf(oovf[3]), .dbg_state_o(dbg[3]));
  leaf_frame_accumulator #(.COUNT(1), .OFFSET(65535), .SHIFT(4'd0), .SAT(1'b1)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[4]), .in_data(in_data),
    .flush(flush), .out_valid(ovld[4]), .out_ready(out_ready), .out_sum(osum[4]),
    .out_count(ocnt[4]), .out_ovf(oovf[4]), .dbg_state_o(dbg[4]));

  // ---------------- reference model ----------------
  typedef struct {
    longint sum;
    int     cnt;
    bit     hold;
    int     osum;
    int     ocnt;
    bit     ovf;
  } mstate_t;

  mstate_t m_st [NI];

  function automatic mstate_t model_reset();
    mstate_t n;
    n.sum = 0; n.cnt = 0; n.hold = 1'b0; n.osum = 0; n.ocnt = 0; n.ovf = 1'b0;
    return n;
  endfunction

  // One clock of frame-level behaviour: gather samples, close on count or flush, then wait for the consumer.
  function automatic mstate_t model_next(int i, mstate_t s);
    mstate_t n;
    longint  t;
    longint  r;
    bit      took;
    bit      closing;
    n = s;
    if (s.hold) begin
      if (out_ready === 1'b1) n.hold = 1'b0;
    end else begin
      took = (in_valid === 1'b1);
      if (took) begin
        n.sum = s.sum + longint'(in_data);
        n.cnt = s.cnt + 1;
      end
      closing = (took && n.cnt == cfg_count[i]) || ((flush === 1'b1) && n.cnt > 0);
      if (closing) begin
        t      = n.sum + longint'(cfg_off[i]);
        r      = t / (longint'(1) << cfg_shift[i]);
        n.ovf  = (r > 65535);
        n.osum = (cfg_sat[i] != 0 && r > 65535) ? 65535 : int'(r % 65536);
        n.ocnt = n.cnt;
        n.sum  = 0;
        n.cnt  = 0;
        n.hold = 1'b1;
      end
    end
    return n;
  endfunction

  initial for (int i = 0; i < NI; i++) m_st[i] = model_reset();

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) m_st[i] <= model_reset();
      else          m_st[i] <= model_next(i, m_st[i]);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0d want=%0d at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("in_ready",  i, 32'(rdy[i]),  32'(!m_st[i].hold));
      chk("out_valid", i, 32'(ovld[i]), 32'(m_st[i].hold));
      chk("dbg_state", i, 32'(dbg[i]),  32'(m_st[i].hold));
      chk("out_sum",   i, 32'(osum[i]), m_st[i].osum);
      chk("out_count", i, 32'(ocnt[i]), m_st[i].ocnt);
      chk("out_ovf",   i, 32'(oovf[i]), 32'(m_st[i].ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  task automatic release_out();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Reset lands between clock edges, away from the negedge compare instant.
  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready",  0, 32'(rdy[0]),  1);
    chk("rst_out_valid", 0, 32'(ovld[0]), 0);
    chk("rst_out_sum",   0, 32'(osum[0]), 0);
    chk("rst_out_count", 0, 32'(ocnt[0]), 0);
    chk("rst_out_valid", 4, 32'(ovld[4]), 0);
    chk("rst_out_ovf",   4, 32'(oovf[4]), 0);
    #2 reset_n = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset_n = 1'b0;
    repeat (2) step();
    chk("reset_in_ready", 0, 32'(rdy[0]), 1);
    chk("reset_sum",      0, 32'(osum[0]), 0);
    #2 reset_n = 1'b1;
    step();

    // Basic frame 1,2,3,4
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    chk("basic_valid", 0, 32'(ovld[0]), 1);
    chk("basic_sum",   0, 32'(osum[0]), 10);
    chk("basic_count", 0, 32'(ocnt[0]), 4);
    chk("basic_ovf",   0, 32'(oovf[0]), 0);
    chk("basic_ready", 0, 32'(rdy[0]),  0);
    chk("avg_small",   1, 32'(osum[1]), 3);
    chk("count1_sum",  4, 32'(osum[4]), 65535);
    chk("count1_ovf",  4, 32'(oovf[4]), 1);
    chk("count1_cnt",  4, 32'(ocnt[4]), 1);

    // Backpressure: held result is stable and incoming samples are ignored
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", 0, 32'(ovld[0]), 1);
      chk("bp_sum",   0, 32'(osum[0]), 10);
      chk("bp_count", 0, 32'(ocnt[0]), 4);
      chk("bp_ready", 0, 32'(rdy[0]),  0);
    end
    release_out();
    chk("post_hs_ready", 0, 32'(rdy[0]),  1);
    chk("post_hs_valid", 0, 32'(ovld[0]), 0);
    chk("post_hs_keep",  0, 32'(osum[0]), 10);

    // Averaging with offset: (100+3)>>2 = 25
    send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
    chk("avg_sum",   1, 32'(osum[1]), 25);
    chk("avg_count", 1, 32'(ocnt[1]), 4);
    chk("fresh_sum", 0, 32'(osum[0]), 100);
    release_out();

    // Flush corners
    send(8'd5, 1'b0); send(8'd6, 1'b0); do_flush();
    chk("flush_sum",   0, 32'(osum[0]), 11);
    chk("flush_count", 0, 32'(ocnt[0]), 2);
    chk("flush_valid", 0, 32'(ovld[0]), 1);
    release_out();
    do_flush();
    chk("flush_empty", 0, 32'(ovld[0]), 0);
    send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b1);
    chk("flush_acc_sum",   0, 32'(osum[0]), 18);
    chk("flush_acc_count", 0, 32'(ocnt[0]), 3);
    release_out();
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b1);
    chk("flush_last_sum",   0, 32'(osum[0]), 4);
    chk("flush_last_count", 0, 32'(ocnt[0]), 4);
    release_out();
    step();
    chk("flush_last_once", 0, 32'(ovld[0]), 0);

    // Overflow: 256 x 255 + 1000 = 66280
    pulse_reset();
    in_valid = 1'b1;
    in_data  = 8'd255;
    repeat (256) step();
    in_valid = 1'b0;
    chk("sat_sum",    2, 32'(osum[2]), 65535);
    chk("sat_ovf",    2, 32'(oovf[2]), 1);
    chk("sat_count",  2, 32'(ocnt[2]), 256);
    chk("wrap_sum",   3, 32'(osum[3]), 744);
    chk("wrap_ovf",   3, 32'(oovf[3]), 1);
    chk("wrap_valid", 3, 32'(ovld[3]), 1);
    release_out();

    // Async reset mid-frame discards the partial frame
    release_out();
    send(8'd1, 1'b0); send(8'd1, 1'b0);
    pulse_reset();
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
    chk("after_rst_sum",   0, 32'(osum[0]), 4);
    chk("after_rst_count", 0, 32'(ocnt[0]), 4);
    release_out();

    // Random traffic: long flush-free stretch first so the 256-sample frames can complete
    for (int k = 0; k < 2500; k++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      flush     = 1'b0;
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    for (int k = 0; k < 2500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (k == 1200) begin
        flush = 1'b0;
        pulse_reset();
      end else begin
        step();
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
